// File: rtl/i2c_frame_tx.sv
// i2c_frame_tx: serialises one arithmetic frame into bytes for an I2C master.
//
// Frame (latched when start is accepted in IDLE):
//   byte 0      : {6'b111111, opcode}
//   bytes 1-4   : op_a, MSB first
//   bytes 5-8   : op_b, MSB first
//   bytes 9-12  : op_ans, MSB first
//   byte 13     : XOR of bytes 0-12, present only when FRAME_CHECKSUM_EN is defined
//
// Parameters:
//   GAP_CYCLES  - idle cycles (tx_valid low) inserted between consecutive bytes
//   ACK_TIMEOUT - cycles a byte may wait for tx_ack before the frame aborts
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start             - frame request, sampled only while ready=1
//   opcode, op_a,
//   op_b, op_ans      - frame contents
//   ready             - idle, a start will be accepted
//   tx_byte, tx_valid - byte presented to the master
//   tx_ack            - master accepted the byte (handshake = tx_valid & tx_ack)
//   tx_nack           - slave NACKed the current byte; aborts the frame
//   done, err         - one-cycle completion / abort pulses
//   byte_idx          - index of the byte being presented (0 = header)
//
// Optional feature macro: FRAME_CHECKSUM_EN (appends the XOR checksum byte).
module i2c_frame_tx #(
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned ACK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_ans,
    output logic        ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ack,
    input  logic        tx_nack,
    output logic        done,
    output logic        err,
    output logic [3:0]  byte_idx
);

`ifdef FRAME_CHECKSUM_EN
    localparam int unsigned NUM_BYTES = 14;
`else
    localparam int unsigned NUM_BYTES = 13;
`endif
    localparam int unsigned BASE_BYTES = 13;
    localparam int unsigned BASE_W     = BASE_BYTES * 8;
    localparam int unsigned FRAME_W    = NUM_BYTES * 8;
    localparam int unsigned WAIT_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [3:0]        LAST_IDX   = 4'(NUM_BYTES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LIMIT  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [3:0]          idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                tx_valid_q, tx_valid_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [BASE_W-1:0]   base_c;
    logic [FRAME_W-1:0]  load_c;
    logic                timeout_c;

    // Frame image as loaded on start; the top byte is always the next to send.
    assign base_c = {6'b111111, opcode, op_a, op_b, op_ans};

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [BASE_W-1:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < int'(BASE_BYTES); i++) begin
            acc = acc ^ bytes[i*8 +: 8];
        end
        return acc;
    endfunction

    assign load_c = {base_c, xor_bytes(base_c)};
`else
    assign load_c = base_c;
`endif

    assign timeout_c = (wait_cnt_q == WAIT_LIMIT);

    // Next-state and next-output logic; outputs are registered from the _d values.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_byte_d  = 8'h00;
        tx_valid_d = 1'b0;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d    = 1'b1;
                idx_d      = 4'd0;
                wait_cnt_d = '0;
                gap_cnt_d  = '0;
                if (start) begin
                    state_d    = SEND;
                    frame_d    = load_c;
                    tx_byte_d  = load_c[FRAME_W-1 -: 8];
                    tx_valid_d = 1'b1;
                    ready_d    = 1'b0;
                end
            end

            SEND: begin
                // NACK beats a simultaneous ACK; timeout only fires while unacked.
                if (tx_nack || (!tx_ack && timeout_c)) begin
                    state_d    = FINISH;
                    err_d      = 1'b1;
                    frame_d    = '0;
                    idx_d      = 4'd0;
                    wait_cnt_d = '0;
                end else if (tx_ack) begin
                    wait_cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        frame_d = '0;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        frame_d = frame_q << 8;
                        if (GAP_CYCLES == 0) begin
                            tx_valid_d = 1'b1;
                            tx_byte_d  = frame_q[FRAME_W-9 -: 8];
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    tx_valid_d = 1'b1;
                    tx_byte_d  = tx_byte_q;
                end
            end

            GAP: begin
                // Frame was already shifted on the handshake, so the top byte is next.
                if (gap_cnt_q == GAP_LIMIT) begin
                    state_d    = SEND;
                    gap_cnt_d  = '0;
                    tx_valid_d = 1'b1;
                    tx_byte_d  = frame_q[FRAME_W-1 -: 8];
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            FINISH: begin
                state_d = IDLE;
                ready_d = 1'b1;
                idx_d   = 4'd0;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= 4'd0;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ready    = ready_q;
    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;
    assign err      = err_q;
    assign byte_idx = idx_q;

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Testbench for i2c_frame_tx: two instances (no gap with a 16-cycle ack
// timeout, and a 2-cycle inter-byte gap), selected through a shared harness.
module tb_i2c_frame_tx;

`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 14;
`else
    localparam int NB = 13;
`endif

    typedef struct {
        bit          sel;        // 0: no-gap instance, 1: gap instance
        logic [1:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ans;
        int          stall_max;  // random ack delay per byte, 0..stall_max
        int          bp_idx;     // byte with a fixed ack delay (-1: none)
        int          bp_len;
        int          nack_at;    // byte that gets NACKed (-1: none)
        int          exp_out;    // 1: done, 2: err
        int          exp_sent;   // bytes handshaked without NACK
    } vec_t;

    logic        clk, rst, start, sel;
    logic [1:0]  opcode;
    logic [31:0] op_a, op_b, op_ans;
    logic        tx_ack, tx_nack;

    logic        ready0, tx_valid0, done0, err0;
    logic [7:0]  tx_byte0;
    logic [3:0]  byte_idx0;
    logic        ready1, tx_valid1, done1, err1;
    logic [7:0]  tx_byte1;
    logic [3:0]  byte_idx1;

    logic        ready, tx_valid, done, err;
    logic [7:0]  tx_byte;
    logic [3:0]  byte_idx;

    int n_tests;
    int n_fail;

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] basic_exp [13];
    vec_t       vecs [8];

    i2c_frame_tx #(.GAP_CYCLES(0), .ACK_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .opcode(opcode),
        .op_a(op_a), .op_b(op_b), .op_ans(op_ans),
        .ready(ready0), .tx_byte(tx_byte0), .tx_valid(tx_valid0),
        .tx_ack(tx_ack), .tx_nack(tx_nack),
        .done(done0), .err(err0), .byte_idx(byte_idx0)
    );

    i2c_frame_tx #(.GAP_CYCLES(2)) u_dut_gap (
        .clk(clk), .rst(rst), .start(start & sel), .opcode(opcode),
        .op_a(op_a), .op_b(op_b), .op_ans(op_ans),
        .ready(ready1), .tx_byte(tx_byte1), .tx_valid(tx_valid1),
        .tx_ack(tx_ack), .tx_nack(tx_nack),
        .done(done1), .err(err1), .byte_idx(byte_idx1)
    );

    assign ready    = sel ? ready1    : ready0;
    assign tx_valid = sel ? tx_valid1 : tx_valid0;
    assign tx_byte  = sel ? tx_byte1  : tx_byte0;
    assign byte_idx = sel ? byte_idx1 : byte_idx0;
    assign done     = sel ? done1     : done0;
    assign err      = sel ? err1      : err0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: header, then each word big-endian, optional XOR byte.
    function automatic void build_expected(input logic [1:0] opc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] ans);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back({6'b111111, opc});
        for (int i = 3; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(b[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(ans[8*i +: 8]);
`ifdef FRAME_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endfunction

    // Drives one frame from an IDLE negedge and returns observed outcome.
    task automatic run_frame(input vec_t v, output int outcome, output int sent);
        int low;
        int stall;
        int gap;
        bit nacked;
        build_expected(v.opc, v.a, v.b, v.ans);
        got.delete();
        outcome = 0;
        sent = 0;
        nacked = 0;
        gap = v.sel ? 2 : 0;
        sel = v.sel;
        #1;
        chk("ready_idle", ready, 1);
        start = 1'b1; opcode = v.opc; op_a = v.a; op_b = v.b; op_ans = v.ans;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            low = 0;
            while (!tx_valid && low < 64) begin
                chk("ready_busy", ready, 0);
                tx_ack = 1'($urandom); tx_nack = 1'($urandom); start = 1'($urandom);
                op_a = $urandom; opcode = 2'($urandom);
                @(negedge clk);
                low++;
            end
            tx_ack = 1'b0; tx_nack = 1'b0; start = 1'b0;
            chk("gap_len", low, (k == 0) ? 0 : gap);
            if (!tx_valid) return;
            stall = (k == v.bp_idx) ? v.bp_len : int'($urandom_range(0, v.stall_max));
            for (int s = 0; s <= stall; s++) begin
                chk("tx_byte", tx_byte, exp_q[k]);
                chk("byte_idx", byte_idx, k);
                start = 1'($urandom); op_b = $urandom; op_ans = $urandom;
                if (s == stall) begin
                    got.push_back(tx_byte);
                    tx_ack = 1'b1;
                    tx_nack = (k == v.nack_at);
                end
                @(negedge clk);
            end
            tx_ack = 1'b0; tx_nack = 1'b0; start = 1'b0;
            if (k == v.nack_at) begin
                nacked = 1;
                break;
            end
            sent++;
        end
        chk("fin_valid", tx_valid, 0);
        chk("fin_ready", ready, 0);
        chk(nacked ? "fin_err" : "fin_done", nacked ? err : done, 1);
        outcome = (done && !err) ? 1 : (err && !done) ? 2 : 0;
        start = 1'b1;
        @(negedge clk);
        chk("post_ready", ready, 1);
        chk("post_valid", tx_valid, 0);
        chk("post_pulse", {done, err}, 0);
        start = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_valid"}, tx_valid, 0);
        chk({tag, "_byte"}, tx_byte, 0);
        chk({tag, "_idx"}, byte_idx, 0);
        chk({tag, "_done_err"}, {done, err}, 0);
    endtask

    initial begin
        vec_t v;
        int outcome, sent, cnt;
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1; start = 1'b0; sel = 1'b0; opcode = 2'b00;
        op_a = '0; op_b = '0; op_ans = '0; tx_ack = 1'b0; tx_nack = 1'b0;

        basic_exp = '{8'hFE, 8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00,
                      8'h40, 8'h80, 8'h00, 8'h00};
        //           sel opc    a             b             ans           smax bp  bpl nack out sent
        vecs[0] = '{0, 2'b10, 32'h40000000, 32'h40000000, 32'h40800000, 0, -1, 0,  -1, 1, NB};
        vecs[1] = '{0, 2'b01, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 0,  3, 5,  -1, 1, NB};
        vecs[2] = '{0, 2'b11, 32'h01020304, 32'hA5A55A5A, 32'hFFFFFFFF, 0, -1, 0,   5, 2, 5};
        vecs[3] = '{0, 2'b00, 32'h89ABCDEF, 32'h00000001, 32'h80000000, 2, -1, 0,  -1, 1, NB};
        vecs[4] = '{0, 2'b10, 32'h11223344, 32'h55667788, 32'h99AABBCC, 0,  6, 15, -1, 1, NB};
        vecs[5] = '{0, 2'b01, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h3C3C3C3C, 0, -1, 0,  NB-1, 2, NB-1};
        vecs[6] = '{1, 2'b00, 32'hCAFEBABE, 32'h0BADF00D, 32'h13579BDF, 2, -1, 0,  -1, 1, NB};
        vecs[7] = '{1, 2'b11, 32'h76543210, 32'hFEDCBA98, 32'h02468ACE, 1, -1, 0,   0, 2, 0};

        repeat (3) @(negedge clk);
        sel = 1'b0; #1;
        chk_idle_outputs("rst0");
        sel = 1'b1; #1;
        chk_idle_outputs("rst1");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], outcome, sent);
            chk("tbl_outcome", outcome, vecs[i].exp_out);
            chk("tbl_sent", sent, vecs[i].exp_sent);
            if (i == 0) begin
                for (int j = 0; j < 13; j++) chk("basic_byte", got[j], basic_exp[j]);
`ifdef FRAME_CHECKSUM_EN
                chk("basic_csum", got[13], 8'h3E);
`endif
            end
        end

        // Ack never arrives: exactly 16 valid cycles, then an err pulse.
        sel = 1'b0; #1;
        start = 1'b1; opcode = 2'b01; op_a = 32'h01234567; op_b = '0; op_ans = '0;
        @(negedge clk);
        start = 1'b0;
        chk("to_header", tx_byte, 8'hFD);
        cnt = 0;
        while (tx_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_cycles", cnt, 16);
        chk("to_err", err, 1);
        chk("to_done", done, 0);
        @(negedge clk);
        chk("to_ready", ready, 1);
        chk("to_err_clear", err, 0);

        // Reset while byte 7 is on the bus: idle outputs next cycle, no err.
        start = 1'b1; opcode = 2'b10; op_a = 32'hAABBCCDD; op_b = 32'h11223344; op_ans = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tx_ack = 1'b1;
            @(negedge clk);
        end
        tx_ack = 1'b0;
        chk("rst_mid_idx", byte_idx, 7);
        chk("rst_mid_byte", tx_byte, 8'h33);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_err", err, 0);
        chk("rst_mid_ready", ready, 1);
        run_frame(vecs[0], outcome, sent);
        chk("rst_recover_outcome", outcome, 1);
        chk("rst_recover_sent", sent, NB);

        // Randomized frames against the reference model.
        for (int i = 0; i < 24; i++) begin
            v.sel = 1'($urandom);
            v.opc = 2'($urandom);
            v.a = $urandom; v.b = $urandom; v.ans = $urandom;
            v.stall_max = int'($urandom_range(0, 4));
            v.bp_idx = -1; v.bp_len = 0;
            v.nack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            v.exp_out = (v.nack_at >= 0) ? 2 : 1;
            v.exp_sent = (v.nack_at >= 0) ? v.nack_at : NB;
            run_frame(v, outcome, sent);
            chk("rnd_outcome", outcome, v.exp_out);
            chk("rnd_sent", sent, v.exp_sent);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
